// File: rtl/jtpang_sdram_arb.sv
// JTPANG SDRAM arbiter: round-robin bank reads, download-priority prog path,
// single-command PHY sequencing with a per-transaction watchdog.
module jtpang_sdram_arb #(
  parameter int BURST = 2,
  parameter int TMO   = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        downloading,
  input  logic [3:0]  ba_rd,
  input  logic [21:0] ba0_addr,
  input  logic [21:0] ba1_addr,
  input  logic [21:0] ba2_addr,
  input  logic [21:0] ba3_addr,
  output logic [3:0]  ba_ack,
  output logic [3:0]  ba_dst,
  output logic [3:0]  ba_dok,
  output logic [3:0]  ba_rdy,
  output logic [15:0] data_read,
  input  logic [21:0] prog_addr,
  input  logic [15:0] prog_data,
  input  logic [1:0]  prog_mask,
  input  logic [1:0]  prog_ba,
  input  logic        prog_we,
  input  logic        prog_rd,
  output logic        prog_ack,
  output logic        prog_rdy,
  output logic        phy_req,
  output logic        phy_wr,
  output logic [1:0]  phy_ba,
  output logic [21:0] phy_addr,
  output logic [15:0] phy_din,
  output logic [1:0]  phy_mask,
  input  logic        phy_ack,
  input  logic        phy_dvld,
  input  logic [15:0] phy_dout,
  input  logic        phy_wdone,
  output logic        tmo_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, RDATA, WDONE} state_t;

  localparam logic [1:0] LAST  = 2'(BURST - 1);
  localparam logic [7:0] WDLIM = 8'(TMO - 1);

  state_t      state_q, state_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [1:0]  ba_q, ba_d;
  logic        prog_q, prog_d;
  logic        wr_q, wr_d;
  logic [21:0] addr_q, addr_d;
  logic [15:0] din_q, din_d;
  logic [1:0]  mask_q, mask_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [7:0]  wd_q, wd_d;
  logic        tmo_q, tmo_d;
  logic [3:0]  ack_q, ack_d;
  logic [3:0]  dst_q, dst_d;
  logic [3:0]  dok_q, dok_d;
  logic [3:0]  rdy_q, rdy_d;
  logic [15:0] data_q, data_d;
  logic        pack_q, pack_d;
  logic        prdy_q, prdy_d;

  logic        found;
  logic [1:0]  pick;
  logic [1:0]  idx;
  logic [21:0] bank_addr;
  logic        wd_hit;

  // Search ptr+1 .. ptr+4 so the last winner has lowest priority
  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    idx   = '0;
    for (int i = 1; i <= 4; i++) begin
      idx = ptr_q + 2'(i);
      if (!found && ba_rd[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    unique case (pick)
      2'd0: bank_addr = ba0_addr;
      2'd1: bank_addr = ba1_addr;
      2'd2: bank_addr = ba2_addr;
      default: bank_addr = ba3_addr;
    endcase
  end

  assign wd_hit = (wd_q == WDLIM);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    ba_d    = ba_q;
    prog_d  = prog_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    din_d   = din_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    wd_d    = wd_q;
    tmo_d   = tmo_q;
    data_d  = data_q;
    ack_d   = '0;
    dst_d   = '0;
    dok_d   = '0;
    rdy_d   = '0;
    pack_d  = 1'b0;
    prdy_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (downloading && (prog_we || prog_rd)) begin
          state_d = ISSUE;
          prog_d  = 1'b1;
          wr_d    = prog_we;
          addr_d  = prog_addr;
          ba_d    = prog_ba;
          din_d   = prog_data;
          mask_d  = prog_mask;
          wd_d    = '0;
        end else if (!downloading && found) begin
          state_d = ISSUE;
          prog_d  = 1'b0;
          wr_d    = 1'b0;
          addr_d  = bank_addr;
          ba_d    = pick;
          ptr_d   = pick;
          din_d   = '0;
          mask_d  = '0;
          wd_d    = '0;
        end
      end
      ISSUE: begin
        wd_d = wd_q + 8'd1;
        if (phy_ack) begin
          if (prog_q) pack_d = 1'b1;
          else        ack_d[ba_q] = 1'b1;
          cnt_d   = '0;
          state_d = wr_q ? WDONE : RDATA;
        end else if (wd_hit) begin
          tmo_d   = 1'b1;
          state_d = IDLE;
        end
      end
      RDATA: begin
        wd_d = wd_q + 8'd1;
        if (phy_dvld) begin
          data_d = phy_dout;
          cnt_d  = cnt_q + 2'd1;
          if (!prog_q) begin
            dok_d[ba_q] = 1'b1;
            dst_d[ba_q] = (cnt_q == 2'd0);
            rdy_d[ba_q] = (cnt_q == LAST);
          end
          if (cnt_q == LAST) begin
            prdy_d  = prog_q;
            state_d = IDLE;
          end
        end else if (wd_hit) begin
          tmo_d   = 1'b1;
          state_d = IDLE;
        end
      end
      WDONE: begin
        wd_d = wd_q + 8'd1;
        if (phy_wdone) begin
          prdy_d  = 1'b1;
          state_d = IDLE;
        end else if (wd_hit) begin
          tmo_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 2'd3;
      ba_q    <= '0;
      prog_q  <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
      wd_q    <= '0;
      tmo_q   <= 1'b0;
      data_q  <= '0;
      ack_q   <= '0;
      dst_q   <= '0;
      dok_q   <= '0;
      rdy_q   <= '0;
      pack_q  <= 1'b0;
      prdy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ba_q    <= ba_d;
      prog_q  <= prog_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      wd_q    <= wd_d;
      tmo_q   <= tmo_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
      dst_q   <= dst_d;
      dok_q   <= dok_d;
      rdy_q   <= rdy_d;
      pack_q  <= pack_d;
      prdy_q  <= prdy_d;
    end
  end

  assign phy_req   = (state_q == ISSUE);
  assign phy_wr    = wr_q;
  assign phy_ba    = ba_q;
  assign phy_addr  = addr_q;
  assign phy_din   = din_q;
  assign phy_mask  = mask_q;
  assign ba_ack    = ack_q;
  assign ba_dst    = dst_q;
  assign ba_dok    = dok_q;
  assign ba_rdy    = rdy_q;
  assign data_read = data_q;
  assign prog_ack  = pack_q;
  assign prog_rdy  = prdy_q;
  assign tmo_err   = tmo_q;

endmodule

// File: tb/tb_jtpang_sdram_arb.sv
// Directed bench for jtpang_sdram_arb: scoreboard of expected read words
// popped whenever a bank data strobe appears.
module tb_jtpang_sdram_arb;

  localparam int BURST = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        downloading = 1'b0;
  logic [3:0]  ba_rd = '0;
  logic [21:0] ba0_addr, ba1_addr, ba2_addr, ba3_addr;
  logic [3:0]  ba_ack, ba_dst, ba_dok, ba_rdy;
  logic [15:0] data_read;
  logic [21:0] prog_addr = '0;
  logic [15:0] prog_data = '0;
  logic [1:0]  prog_mask = '0;
  logic [1:0]  prog_ba = '0;
  logic        prog_we = 1'b0;
  logic        prog_rd = 1'b0;
  logic        prog_ack, prog_rdy;
  logic        phy_req, phy_wr;
  logic [1:0]  phy_ba;
  logic [21:0] phy_addr;
  logic [15:0] phy_din;
  logic [1:0]  phy_mask;
  logic        phy_ack = 1'b0;
  logic        phy_dvld = 1'b0;
  logic [15:0] phy_dout = '0;
  logic        phy_wdone = 1'b0;
  logic        tmo_err;

  typedef struct {
    int          b;
    logic [15:0] d;
    logic        dst;
    logic        rdy;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  int          ack_cnt[4] = '{0, 0, 0, 0};
  int          a0[4];
  logic [21:0] A[4] = '{22'h000100, 22'h011111, 22'h012345, 22'h033333};

  always #5 clk = ~clk;

  assign ba0_addr = A[0];
  assign ba1_addr = A[1];
  assign ba2_addr = A[2];
  assign ba3_addr = A[3];

  jtpang_sdram_arb #(.BURST(BURST), .TMO(255)) dut (
    .clk(clk), .rst_n(rst_n), .downloading(downloading),
    .ba_rd(ba_rd),
    .ba0_addr(ba0_addr), .ba1_addr(ba1_addr),
    .ba2_addr(ba2_addr), .ba3_addr(ba3_addr),
    .ba_ack(ba_ack), .ba_dst(ba_dst), .ba_dok(ba_dok), .ba_rdy(ba_rdy),
    .data_read(data_read),
    .prog_addr(prog_addr), .prog_data(prog_data),
    .prog_mask(prog_mask), .prog_ba(prog_ba),
    .prog_we(prog_we), .prog_rd(prog_rd),
    .prog_ack(prog_ack), .prog_rdy(prog_rdy),
    .phy_req(phy_req), .phy_wr(phy_wr), .phy_ba(phy_ba),
    .phy_addr(phy_addr), .phy_din(phy_din), .phy_mask(phy_mask),
    .phy_ack(phy_ack), .phy_dvld(phy_dvld), .phy_dout(phy_dout),
    .phy_wdone(phy_wdone), .tmo_err(tmo_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard pop and ack tally, run once per cycle at the falling edge
  task automatic mon();
    exp_t e;
    if (rst_n) begin
      for (int i = 0; i < 4; i++)
        if (ba_ack[i]) ack_cnt[i]++;
      if ((ba_dok | ba_dst | ba_rdy) != 4'b0) begin
        chk("sb_unexpected", (sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("sb_dok", ba_dok, 4'b1 << e.b);
          chk("sb_dst", ba_dst, e.dst ? (4'b1 << e.b) : 4'b0);
          chk("sb_rdy", ba_rdy, e.rdy ? (4'b1 << e.b) : 4'b0);
          chk("sb_data", data_read, e.d);
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    mon();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ba_rd = '0;
    downloading = 1'b0;
    prog_we = 1'b0;
    prog_rd = 1'b0;
    phy_ack = 1'b0;
    phy_dvld = 1'b0;
    phy_wdone = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (phy_req !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk(tag, phy_req, 1);
  endtask

  task automatic bank_read(input int b, input int dly, input bit drop,
                           input logic [15:0] d0, input logic [15:0] d1,
                           input string tag);
    logic [15:0] dat;
    wait_req({tag, "_req"});
    chk({tag, "_ba"}, phy_ba, b);
    chk({tag, "_addr"}, phy_addr, A[b]);
    chk({tag, "_wr"}, phy_wr, 0);
    for (int i = 0; i < dly; i++) begin
      tick();
      chk({tag, "_req_hold"}, phy_req, 1);
    end
    phy_ack = 1'b1;
    tick();
    phy_ack = 1'b0;
    chk({tag, "_ack"}, ba_ack, 4'b1 << b);
    chk({tag, "_req_drop"}, phy_req, 0);
    if (drop) ba_rd[b] = 1'b0;
    for (int w = 0; w < BURST; w++) begin
      dat = (w == 0) ? d0 : 16'(d1 + 16'(w - 1));
      phy_dvld = 1'b1;
      phy_dout = dat;
      sb.push_back('{b: b, d: dat, dst: (w == 0), rdy: (w == BURST - 1)});
      tick();
      chk({tag, "_dok_lat"}, ba_dok, 4'b1 << b);
    end
    phy_dvld = 1'b0;
  endtask

  initial begin
    int n;
    do_reset();

    // reset state
    chk("rst_req", phy_req, 0);
    chk("rst_ack", ba_ack, 0);
    chk("rst_dok", ba_dok, 0);
    chk("rst_data", data_read, 0);
    chk("rst_tmo", tmo_err, 0);
    chk("rst_pack", prog_ack, 0);

    // stray phy_dvld in IDLE produces nothing
    phy_dvld = 1'b1;
    phy_dout = 16'h1234;
    tick();
    phy_dvld = 1'b0;
    chk("stray_dvld", ba_dok, 0);

    // single read on bank 2
    a0 = ack_cnt;
    ba_rd = 4'b0100;
    tick();
    chk("t1_grant_lat", phy_req, 1);
    bank_read(2, 3, 1'b1, 16'hAAAA, 16'h5555, "t1");
    tick();
    chk("t1_idle", phy_req, 0);
    chk("t1_ack_once", ack_cnt[2] - a0[2], 1);

    // round robin from reset
    do_reset();
    a0 = ack_cnt;
    ba_rd = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      bank_read(k % 4, 0, 1'b0, 16'(16'hD000 + k * 16),
                16'(16'hE000 + k * 16), "rr");
      if (k == 4) ba_rd = '0;
      chk("rr_turn", phy_req, 0);
    end
    tick();
    chk("rr_quiet", phy_req, 0);
    chk("rr_cnt0", ack_cnt[0] - a0[0], 2);
    chk("rr_cnt1", ack_cnt[1] - a0[1], 1);
    chk("rr_cnt2", ack_cnt[2] - a0[2], 1);
    chk("rr_cnt3", ack_cnt[3] - a0[3], 1);

    // download priority: write then read
    do_reset();
    a0 = ack_cnt;
    downloading = 1'b1;
    ba_rd = 4'b0001;
    prog_we = 1'b1;
    prog_addr = 22'h000010;
    prog_data = 16'hBEEF;
    prog_mask = 2'b01;
    prog_ba = 2'd1;
    tick();
    chk("dl_req", phy_req, 1);
    chk("dl_wr", phy_wr, 1);
    chk("dl_din", phy_din, 16'hBEEF);
    chk("dl_addr", phy_addr, 22'h000010);
    chk("dl_ba", phy_ba, 1);
    chk("dl_mask", phy_mask, 2'b01);
    prog_data = 16'h0000;
    tick();
    chk("dl_din_latched", phy_din, 16'hBEEF);
    phy_ack = 1'b1;
    tick();
    phy_ack = 1'b0;
    prog_we = 1'b0;
    chk("dl_pack", prog_ack, 1);
    chk("dl_no_back", ba_ack, 0);
    chk("dl_req_drop", phy_req, 0);
    tick();
    phy_wdone = 1'b1;
    tick();
    phy_wdone = 1'b0;
    chk("dl_prdy", prog_rdy, 1);
    tick();
    chk("dl_prdy_pulse", prog_rdy, 0);
    prog_rd = 1'b1;
    prog_addr = 22'h000020;
    prog_ba = 2'd2;
    tick();
    chk("dr_req", phy_req, 1);
    chk("dr_wr", phy_wr, 0);
    chk("dr_ba", phy_ba, 2);
    phy_ack = 1'b1;
    tick();
    phy_ack = 1'b0;
    prog_rd = 1'b0;
    chk("dr_pack", prog_ack, 1);
    phy_dvld = 1'b1;
    phy_dout = 16'h1111;
    tick();
    chk("dr_w0", data_read, 16'h1111);
    chk("dr_prdy_early", prog_rdy, 0);
    phy_dout = 16'h2222;
    tick();
    phy_dvld = 1'b0;
    chk("dr_w1", data_read, 16'h2222);
    chk("dr_prdy", prog_rdy, 1);
    tick();
    tick();
    chk("dl_bank_blocked", phy_req, 0);
    chk("dl_no_bank_ack", ack_cnt[0] - a0[0], 0);
    downloading = 1'b0;
    bank_read(0, 1, 1'b1, 16'h0F0F, 16'hF0F0, "dl_after");

    // watchdog
    do_reset();
    a0 = ack_cnt;
    ba_rd = 4'b0010;
    tick();
    chk("wd_req", phy_req, 1);
    chk("wd_ba", phy_ba, 1);
    n = 0;
    while (phy_req === 1'b1 && n < 300) begin
      n++;
      tick();
    end
    chk("wd_cycles", n, 255);
    chk("wd_tmo", tmo_err, 1);
    chk("wd_no_ack", ack_cnt[1] - a0[1], 0);
    tick();
    chk("wd_reissue", phy_req, 1);
    chk("wd_reissue_ba", phy_ba, 1);
    bank_read(1, 0, 1'b1, 16'h7777, 16'h8888, "wd_rd");
    chk("wd_sticky", tmo_err, 1);

    // async reset in the middle of a bank-3 burst
    do_reset();
    chk("wd_tmo_clr", tmo_err, 0);
    ba_rd = 4'b1000;
    wait_req("mr_req");
    chk("mr_ba", phy_ba, 3);
    phy_ack = 1'b1;
    tick();
    phy_ack = 1'b0;
    ba_rd = '0;
    phy_dvld = 1'b1;
    phy_dout = 16'h3333;
    sb.push_back('{b: 3, d: 16'h3333, dst: 1'b1, rdy: 1'b0});
    tick();
    phy_dvld = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mr_dok0", ba_dok, 0);
    chk("mr_dst0", ba_dst, 0);
    chk("mr_data0", data_read, 0);
    chk("mr_req0", phy_req, 0);
    tick();
    rst_n = 1'b1;
    phy_dvld = 1'b1;
    phy_dout = 16'h4444;
    tick();
    phy_dvld = 1'b0;
    chk("mr_no_rdy", ba_rdy, 0);
    tick();
    chk("mr_no_rdy2", ba_rdy, 0);
    ba_rd = 4'b1001;
    bank_read(0, 0, 1'b1, 16'h5A5A, 16'hA5A5, "mr_next");
    ba_rd = '0;
    tick();
    chk("mr_quiet", phy_req, 0);

    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
